// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control unit: MEM-stage control ops, exception codes,
// control-register indices, STATUS bit positions and FSM states.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        CtrlNop  = 2'd0,
        CtrlWrcr = 2'd1,
        CtrlExrt = 2'd2
    } ctrl_op_e;

    typedef enum logic [2:0] {
        ExpNone     = 3'd0,
        ExpExtInt   = 3'd1,
        ExpUndef    = 3'd2,
        ExpOverflow = 3'd3,
        ExpMisalign = 3'd4,
        ExpTrap     = 3'd5,
        ExpPriv     = 3'd6
    } exp_code_e;

    localparam logic [4:0] CrStatus    = 5'd0;
    localparam logic [4:0] CrPreStatus = 5'd1;
    localparam logic [4:0] CrEpc       = 5'd2;
    localparam logic [4:0] CrExpVector = 5'd3;
    localparam logic [4:0] CrCause     = 5'd4;
    localparam logic [4:0] CrIntMask   = 5'd5;
    localparam logic [4:0] CrIrqPend   = 5'd6;
    localparam logic [4:0] CrPerf      = 5'd7;

    localparam int unsigned StatusExeMode = 0;
    localparam int unsigned StatusIntEn   = 1;

    localparam logic [1:0] StRun      = 2'd0;
    localparam logic [1:0] StHold     = 2'd1;
    localparam logic [1:0] StRedirect = 2'd2;

endpackage

// File: rtl/pipe_ctrl_creg.sv
// Control-register file with IRQ synchroniser. Defining PIPE_CTRL_PERF_EN adds a
// stall-cycle counter at index 7.
module pipe_ctrl_creg
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned IRQ_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IRQ_W-1:0] irq,
    input  logic [4:0]       rd_addr,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [31:0]      wr_data,
    input  logic             exp_capture,
    input  logic [2:0]       exp_code,
    input  logic [29:0]      exp_pc,
    input  logic             exrt_restore,
    input  logic             stall_any,
    output logic [1:0]       status,
    output logic [29:0]      epc,
    output logic [29:0]      exp_vector,
    output logic             int_detect
);

    logic [1:0]       status_q, pre_status_q;
    logic [29:0]      epc_q, exp_vector_q;
    logic [2:0]       cause_q;
    logic [IRQ_W-1:0] int_mask_q, irq_meta_q, irq_sync_q;
    logic [IRQ_W-1:0] irq_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_q     <= '0;
            pre_status_q <= '0;
            epc_q        <= '0;
            exp_vector_q <= '0;
            cause_q      <= '0;
            int_mask_q   <= '1;
            irq_meta_q   <= '0;
            irq_sync_q   <= '0;
        end else begin
            irq_meta_q <= irq;
            irq_sync_q <= irq_meta_q;
            if (exp_capture) begin
                epc_q        <= exp_pc;
                cause_q      <= exp_code;
                pre_status_q <= status_q;
                status_q     <= 2'b00;
            end else if (exrt_restore) begin
                status_q <= pre_status_q;
            end else if (wr_en) begin
                case (wr_addr)
                    CrStatus:    status_q     <= wr_data[1:0];
                    CrPreStatus: pre_status_q <= wr_data[1:0];
                    CrEpc:       epc_q        <= wr_data[29:0];
                    CrExpVector: exp_vector_q <= wr_data[29:0];
                    CrCause:     cause_q      <= wr_data[2:0];
                    CrIntMask:   int_mask_q   <= wr_data[IRQ_W-1:0];
                    default: ;
                endcase
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_q;

    // A WRCR to the counter both clears (data 0) and preloads it; it wins over counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_q <= '0;
        end else if (wr_en && (wr_addr == CrPerf)) begin
            perf_q <= wr_data;
        end else if (stall_any) begin
            perf_q <= perf_q + 32'd1;
        end
    end
`else
    logic unused_perf;
    assign unused_perf = ^{wr_data[31:30], stall_any};
`endif

    assign irq_pend   = irq_sync_q & ~int_mask_q;
    assign int_detect = status_q[StatusIntEn] & (|irq_pend);
    assign status     = status_q;
    assign epc        = epc_q;
    assign exp_vector = exp_vector_q;

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            CrStatus:    rd_data[1:0]       = status_q;
            CrPreStatus: rd_data[1:0]       = pre_status_q;
            CrEpc:       rd_data[29:0]      = epc_q;
            CrExpVector: rd_data[29:0]      = exp_vector_q;
            CrCause:     rd_data[2:0]       = cause_q;
            CrIntMask:   rd_data[IRQ_W-1:0] = int_mask_q;
            CrIrqPend:   rd_data[IRQ_W-1:0] = irq_pend;
`ifdef PIPE_CTRL_PERF_EN
            CrPerf:      rd_data            = perf_q;
`endif
            default:     rd_data            = '0;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush generation and exception entry/return sequencing.
// Optional stall-cycle counter enabled by PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned IRQ_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_busy,
    input  logic             mem_busy,
    input  logic             ld_hazard,
    input  logic [IRQ_W-1:0] irq,
    input  logic             mem_en,
    input  logic [29:0]      mem_pc,
    input  logic [1:0]       mem_ctrl_op,
    input  logic [2:0]       mem_exp_code,
    input  logic [4:0]       mem_dst_addr,
    input  logic [31:0]      mem_out,
    input  logic [4:0]       creg_rd_addr,
    output logic [31:0]      creg_rd_data,
    output logic             exe_mode,
    output logic             int_detect,
    output logic             if_stall,
    output logic             id_stall,
    output logic             ex_stall,
    output logic             mem_stall,
    output logic             if_flush,
    output logic             id_flush,
    output logic             ex_flush,
    output logic             mem_flush,
    output logic [29:0]      new_pc
);

    logic [1:0]  state_q, state_d;
    logic        ev_exp_q, ev_exp_d;
    logic        base_stall, is_exp, is_exrt, run_event;
    logic [3:0]  stall_raw, flush;
    logic        wr_en;
    logic [1:0]  status;
    logic [29:0] epc, exp_vector;

    assign base_stall = if_busy | mem_busy;
    assign is_exp     = mem_en & (mem_exp_code != ExpNone);
    assign is_exrt    = mem_en & (mem_ctrl_op == CtrlExrt);
    // Events are only sampled in RUN: the event instruction stays in MEM until flushed.
    assign run_event  = (state_q == StRun) & (is_exp | is_exrt);

    always_comb begin
        state_d   = state_q;
        ev_exp_d  = ev_exp_q;
        stall_raw = 4'b0000;
        flush     = 4'b0000;
        case (state_q)
            StRun: begin
                if (run_event) begin
                    stall_raw = 4'b1111;
                    ev_exp_d  = is_exp;
                    state_d   = mem_busy ? StHold : StRedirect;
                end else begin
                    stall_raw = {base_stall | ld_hazard, {3{base_stall}}};
                    flush[2]  = ld_hazard & ~base_stall;
                end
            end
            StHold: begin
                stall_raw = 4'b1111;
                if (!mem_busy) state_d = StRedirect;
            end
            StRedirect: begin
                flush   = 4'b1111;
                state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    // Bit order {if, id, ex, mem}; a flush always beats a stall on the same stage.
    assign {if_stall, id_stall, ex_stall, mem_stall} = stall_raw & ~flush;
    assign {if_flush, id_flush, ex_flush, mem_flush} = flush;

    assign new_pc = (state_q == StRedirect) ? (ev_exp_q ? exp_vector : epc) : '0;
    assign wr_en  = (state_q == StRun) & mem_en & (mem_ctrl_op == CtrlWrcr) &
                    (mem_exp_code == ExpNone) & ~mem_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StRun;
            ev_exp_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ev_exp_q <= ev_exp_d;
        end
    end

    pipe_ctrl_creg #(
        .IRQ_W(IRQ_W)
    ) u_creg (
        .clk         (clk),
        .reset       (reset),
        .irq         (irq),
        .rd_addr     (creg_rd_addr),
        .rd_data     (creg_rd_data),
        .wr_en       (wr_en),
        .wr_addr     (mem_dst_addr),
        .wr_data     (mem_out),
        .exp_capture (run_event & is_exp),
        .exp_code    (mem_exp_code),
        .exp_pc      (mem_pc),
        .exrt_restore(run_event & ~is_exp),
        .stall_any   (if_stall | id_stall | ex_stall | mem_stall),
        .status      (status),
        .epc         (epc),
        .exp_vector  (exp_vector),
        .int_detect  (int_detect)
    );

    assign exe_mode = status[StatusExeMode];

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: vector table for RUN-state stall/flush decode plus
// hand-written exception, EXRT, interrupt, perf-counter and reset sequences.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_busy, mem_busy, ld_hazard;
    logic [7:0]  irq;
    logic        mem_en;
    logic [29:0] mem_pc;
    logic [1:0]  mem_ctrl_op;
    logic [2:0]  mem_exp_code;
    logic [4:0]  mem_dst_addr;
    logic [31:0] mem_out;
    logic [4:0]  creg_rd_addr;
    logic [31:0] creg_rd_data;
    logic        exe_mode, int_detect;
    logic        if_stall, id_stall, ex_stall, mem_stall;
    logic        if_flush, id_flush, ex_flush, mem_flush;
    logic [29:0] new_pc;
    logic [7:0]  ctl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .IRQ_W(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_busy     (if_busy),
        .mem_busy    (mem_busy),
        .ld_hazard   (ld_hazard),
        .irq         (irq),
        .mem_en      (mem_en),
        .mem_pc      (mem_pc),
        .mem_ctrl_op (mem_ctrl_op),
        .mem_exp_code(mem_exp_code),
        .mem_dst_addr(mem_dst_addr),
        .mem_out     (mem_out),
        .creg_rd_addr(creg_rd_addr),
        .creg_rd_data(creg_rd_data),
        .exe_mode    (exe_mode),
        .int_detect  (int_detect),
        .if_stall    (if_stall),
        .id_stall    (id_stall),
        .ex_stall    (ex_stall),
        .mem_stall   (mem_stall),
        .if_flush    (if_flush),
        .id_flush    (id_flush),
        .ex_flush    (ex_flush),
        .mem_flush   (mem_flush),
        .new_pc      (new_pc)
    );

    // {if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush, mem_flush}
    assign ctl = {if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush, mem_flush};

    typedef struct {
        string      name;
        logic       if_busy;
        logic       mem_busy;
        logic       ld_hazard;
        logic [7:0] exp_ctl;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_cr(input string name, input logic [4:0] addr, input logic [31:0] exp);
        creg_rd_addr = addr;
        #1;
        check(name, creg_rd_data, exp);
    endtask

    task automatic wrcr(input logic [4:0] addr, input logic [31:0] data);
        mem_en       = 1'b1;
        mem_ctrl_op  = 2'd1;
        mem_exp_code = 3'd0;
        mem_dst_addr = addr;
        mem_out      = data;
        tick();
        mem_en      = 1'b0;
        mem_ctrl_op = 2'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"idle",        1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{"ld_hazard",   1'b0, 1'b0, 1'b1, 8'h84};
        vecs[2] = '{"ld_if_busy",  1'b1, 1'b0, 1'b1, 8'hF0};
        vecs[3] = '{"mem_busy",    1'b0, 1'b1, 1'b0, 8'hF0};
        vecs[4] = '{"if_busy",     1'b1, 1'b0, 1'b0, 8'hF0};
        vecs[5] = '{"ld_mem_busy", 1'b0, 1'b1, 1'b1, 8'hF0};

        reset = 1'b1;
        {if_busy, mem_busy, ld_hazard, mem_en} = '0;
        irq = '0; mem_pc = '0; mem_ctrl_op = '0; mem_exp_code = '0;
        mem_dst_addr = '0; mem_out = '0; creg_rd_addr = '0;

        // Reset state
        #12;
        check("rst_ctl", {24'b0, ctl}, 32'h00);
        check("rst_new_pc", {2'b0, new_pc}, 32'h0);
        check("rst_int_detect", {31'b0, int_detect}, 32'h0);
        check("rst_exe_mode", {31'b0, exe_mode}, 32'h0);
        check_cr("rst_status", 5'd0, 32'h0);
        check_cr("rst_int_mask", 5'd5, 32'hFF);
        tick();
        reset = 1'b0;
        tick();

        // RUN-state stall/flush decode
        foreach (vecs[i]) begin
            if_busy   = vecs[i].if_busy;
            mem_busy  = vecs[i].mem_busy;
            ld_hazard = vecs[i].ld_hazard;
            #1;
            check(vecs[i].name, {24'b0, ctl}, {24'b0, vecs[i].exp_ctl});
            tick();
        end
        {if_busy, mem_busy, ld_hazard} = '0;

        // WRCR: old value visible during the write cycle, new value after
        mem_en = 1'b1; mem_ctrl_op = 2'd1; mem_dst_addr = 5'd3; mem_out = 32'h40;
        check_cr("wrcr_old", 5'd3, 32'h0);
        tick();
        mem_en = 1'b0; mem_ctrl_op = 2'd0;
        check_cr("wrcr_new", 5'd3, 32'h40);
        wrcr(5'd0, 32'h3);
        #1;
        check("exe_mode_user", {31'b0, exe_mode}, 32'h1);

        // Overflow exception, no bus wait
        mem_en = 1'b1; mem_exp_code = 3'd3; mem_pc = 30'h100;
        #1;
        check("exc_event_ctl", {24'b0, ctl}, 32'hF0);
        tick();
        check("exc_redirect_ctl", {24'b0, ctl}, 32'h0F);
        check("exc_new_pc", {2'b0, new_pc}, 32'h40);
        tick();
        mem_en = 1'b0; mem_exp_code = 3'd0;
        #1;
        check("exc_back_run", {24'b0, ctl}, 32'h00);
        check_cr("exc_epc", 5'd2, 32'h100);
        check_cr("exc_cause", 5'd4, 32'h3);
        tick();
        check_cr("exc_pre_status", 5'd1, 32'h3);
        check_cr("exc_status", 5'd0, 32'h0);
        check("exc_exe_mode", {31'b0, exe_mode}, 32'h0);

        // Misalign exception with mem_busy high for 3 cycles
        wrcr(5'd0, 32'h3);
        mem_en = 1'b1; mem_exp_code = 3'd4; mem_pc = 30'h100; mem_busy = 1'b1;
        #1;
        check("hold_event_ctl", {24'b0, ctl}, 32'hF0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("hold_busy_ctl", {24'b0, ctl}, 32'hF0);
        end
        tick();
        mem_busy = 1'b0;
        #1;
        check("hold_last_ctl", {24'b0, ctl}, 32'hF0);
        tick();
        check("hold_redirect_ctl", {24'b0, ctl}, 32'h0F);
        check("hold_new_pc", {2'b0, new_pc}, 32'h40);
        tick();
        mem_en = 1'b0; mem_exp_code = 3'd0;
        #1;
        check("hold_back_run", {24'b0, ctl}, 32'h00);
        check_cr("hold_cause", 5'd4, 32'h4);
        check_cr("hold_pre_status", 5'd1, 32'h3);
        tick();
        check_cr("hold_status", 5'd0, 32'h0);

        // Exception return
        mem_en = 1'b1; mem_ctrl_op = 2'd2;
        #1;
        check("exrt_event_ctl", {24'b0, ctl}, 32'hF0);
        tick();
        check("exrt_redirect_ctl", {24'b0, ctl}, 32'h0F);
        check("exrt_new_pc", {2'b0, new_pc}, 32'h100);
        tick();
        mem_en = 1'b0; mem_ctrl_op = 2'd0;
        check_cr("exrt_status", 5'd0, 32'h3);
        check("exrt_exe_mode", {31'b0, exe_mode}, 32'h1);

        // Interrupts through the synchroniser and mask
        wrcr(5'd5, 32'hFE);
        #1;
        check("irq_none", {31'b0, int_detect}, 32'h0);
        irq = 8'h01;
        tick();
        check("irq_after_1", {31'b0, int_detect}, 32'h0);
        tick();
        check("irq_after_2", {31'b0, int_detect}, 32'h1);
        check_cr("irq_pend", 5'd6, 32'h1);
        irq = 8'h02;
        tick();
        tick();
        check("irq_masked", {31'b0, int_detect}, 32'h0);
        check_cr("irq_pend_masked", 5'd6, 32'h0);
        irq = 8'h01;
        tick();
        tick();
        wrcr(5'd0, 32'h1);
        #1;
        check("irq_int_en_off", {31'b0, int_detect}, 32'h0);
        irq = 8'h00;

        // Unimplemented index ignores writes
        wrcr(5'd9, 32'h1234);
        check_cr("unimpl_read", 5'd9, 32'h0);

`ifdef PIPE_CTRL_PERF_EN
        wrcr(5'd7, 32'h0);
        check_cr("perf_clear", 5'd7, 32'h0);
        if_busy = 1'b1;
        repeat (5) tick();
        if_busy = 1'b0;
        check_cr("perf_five", 5'd7, 32'h5);
        wrcr(5'd7, 32'hFFFF_FFFF);
        check_cr("perf_preload", 5'd7, 32'hFFFF_FFFF);
        if_busy = 1'b1;
        tick();
        if_busy = 1'b0;
        check_cr("perf_wrap", 5'd7, 32'h0);
`else
        if_busy = 1'b1;
        tick();
        if_busy = 1'b0;
        check_cr("perf_absent", 5'd7, 32'h0);
`endif

        // Asynchronous reset while in HOLD
        mem_en = 1'b1; mem_exp_code = 3'd2; mem_pc = 30'h200; mem_busy = 1'b1;
        tick();
        mem_en = 1'b0; mem_exp_code = 3'd0; mem_busy = 1'b0;
        #1;
        check("pre_reset_hold", {24'b0, ctl}, 32'hF0);
        reset = 1'b1;
        #1;
        check("reset_mid_hold", {24'b0, ctl}, 32'h00);
        check_cr("reset_status", 5'd0, 32'h0);
        check_cr("reset_cause", 5'd4, 32'h0);
        check("reset_exe_mode", {31'b0, exe_mode}, 32'h0);
        reset = 1'b0;
        tick();
        check("after_reset_run", {24'b0, ctl}, 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage CPU. It generates the per-stage stall and flush signals from bus-busy and load-hazard inputs, and sequences exception entry and return (EXRT) through a small state machine. It also owns the control-register file read by the ID stage and written by MEM-stage WRCR operations. It sits beside the IF/ID/EX/MEM stage tops and drives their `stall`/`flush` inputs, plus `new_pc` into IF.

## Interface
- IRQ_W, 8, number of external interrupt lines
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- if_busy  in  1  IF bus access not complete
- mem_busy  in  1  MEM bus access not complete
- ld_hazard  in  1  load-use hazard flagged by ID
- irq  in  IRQ_W  external interrupt lines, level, asynchronous
- mem_en  in  1  MEM-stage register holds a valid instruction
- mem_pc  in  30  word address of the MEM-stage instruction
- mem_ctrl_op  in  2  0 NOP, 1 WRCR, 2 EXRT
- mem_exp_code  in  3  0 none, 1 ext-int, 2 undef, 3 overflow, 4 misalign, 5 trap, 6 priv
- mem_dst_addr  in  5  control-register index for WRCR
- mem_out  in  32  WRCR write data
- creg_rd_addr  in  5  ID read index
- creg_rd_data  out  32  combinational read data
- exe_mode  out  1  0 kernel, 1 user (STATUS[0])
- int_detect  out  1  unmasked pending interrupt with STATUS[1] set
- if_stall, id_stall, ex_stall, mem_stall  out  1 each  stage hold
- if_flush, id_flush, ex_flush, mem_flush  out  1 each  stage bubble
- new_pc  out  30  redirect target, valid while if_flush=1

## Operation
- Control registers:
  - 0 STATUS[1:0] (int_en, exe_mode).
  - 1 PRE_STATUS[1:0].
  - 2 EPC[29:0].
  - 3 EXP_VECTOR[29:0].
  - 4 CAUSE[2:0].
  - 5 INT_MASK[IRQ_W-1:0]; 1 means masked.
  - 6 IRQ_PEND, read-only.
  - Unimplemented indices read 0 and ignore writes.
- irq is double-flop synchronised. IRQ_PEND = irq_sync & ~INT_MASK. int_detect = STATUS[1] & |IRQ_PEND.
- Event: mem_en=1 and either mem_exp_code≠0 or mem_ctrl_op=EXRT. Exceptions take priority over EXRT/WRCR.
- WRCR with mem_en=1, no exception and no stall writes at the clock edge.
- States:
  - RUN: base stalls = if_busy|mem_busy.
    - if_stall = base|ld_hazard; id/ex/mem_stall = base.
    - id_flush = ld_hazard & ~base.
    - On an event: mem_busy=1 → HOLD; mem_busy=0 → REDIRECT.
    - All stalls are asserted in the event cycle, freezing younger stages.
  - HOLD: all stalls=1, no flushes. Event captured in registers. → REDIRECT when mem_busy=0.
  - REDIRECT (exactly 1 cycle): all four flushes=1, all stalls=0. → RUN.
    - Exception: new_pc=EXP_VECTOR.
    - EXRT: new_pc=EPC.
- Exception capture (at entry edge to REDIRECT or HOLD):
  - EPC=mem_pc; CAUSE=code; PRE_STATUS=STATUS; STATUS=2'b00.
- EXRT capture: STATUS=PRE_STATUS.
- Flush overrides stall on the same stage.

## Timing
- Reset values:
  - STATUS=0, PRE_STATUS=0, EPC=0, EXP_VECTOR=0, CAUSE=0, INT_MASK=all ones, irq syncs=0.
  - State=RUN; all stalls/flushes=0; new_pc=0; int_detect=0.
- Stall/flush outputs are combinational from state plus current inputs; no added latency.
- Exception at MEM in cycle N with mem_busy=0:
  - N: stalls.
  - N+1: flushes and new_pc.
  - N+2: IF fetches the vector.
- mem_busy high for k cycles: REDIRECT is delayed by k cycles.
- IRQ to int_detect: 2 cycles after the irq change (synchroniser), +0 after a mask/STATUS write becomes visible the following cycle.
- creg_rd_data reads the old value during the WRCR write cycle; no bypass.
- Reset mid-HOLD/REDIRECT: immediate return to RUN with reset values.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - Adds control register 7, a 32-bit stall-cycle counter.
  - Increments each cycle any *_stall=1.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared by WRCR to index 7.
  - Resets to 0.
- Undefined: index 7 reads 0; no counter logic.

## Structure
- Shared package/header: CtrlOp encodings, exception codes, control-register indices, STATUS bit positions, state encoding.
- One sub-module: pipe_ctrl_creg (register file, IRQ synchroniser, optional perf counter). The FSM and stall/flush logic stay in pipe_ctrl.

## Test plan
- Load hazard: ld_hazard=1, busy=0 → if_stall=1, id_flush=1, others 0; with if_busy=1 → id_flush=0, all stalls=1.
- Overflow exception: mem_exp_code=3 at mem_pc=0x100, EXP_VECTOR=0x40, STATUS=2'b11.
  - Next cycle: all flushes, new_pc=0x40.
  - After: EPC=0x100, CAUSE=3, PRE_STATUS=3, STATUS=0.
- Exception with mem_busy=1 for 3 cycles → 3 HOLD cycles with all stalls, then 1 REDIRECT cycle.
- EXRT after the case above → new_pc=0x100, STATUS=3.
- Interrupt:
  - INT_MASK=0xFE, STATUS[1]=1; irq[0]=1 → int_detect=1 two cycles later.
  - irq[1] alone → int_detect=0.
- PIPE_CTRL_PERF_EN: 5 stall cycles → creg 7 reads 5; WRCR to index 7 → 0; preload 0xFFFFFFFF plus 1 stall → 0.
